battle_turn_ctrl: RTL

Turn sequencer for a one-player-versus-CPU battle. It alternates player and CPU turns and hands each non-standby attack to the shared attack-resolution unit over a request/valid handshake. It applies the returned hit result as saturating damage to the two health registers and declares the winner. It sits between the player input/CPU-type generator and the attack resolver, and it owns the authoritative health values driven to the display.

---
 rtl/battle_pkg.sv | 22 ++
 rtl/damage_calc.sv | 23 ++
 rtl/battle_turn_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/battle_pkg.sv
// Shared encodings for the battle turn sequencer: attack types, hit results and FSM states.
package battle_pkg;
  localparam int DEF_MAX_HEALTH = 100;

  localparam logic [1:0] ATK_STANDBY = 2'b00;
  localparam logic [1:0] ATK_LIGHT   = 2'b01;
  localparam logic [1:0] ATK_HEAVY   = 2'b10;

  localparam logic [1:0] HIT_NONE    = 2'b00;
  localparam logic [1:0] HIT_CRIT    = 2'b01;
  localparam logic [1:0] HIT_NORMAL  = 2'b10;
  localparam logic [1:0] HIT_MISS    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_P1_TURN, S_P1_RESOLVE, S_CPU_TURN, S_CPU_RESOLVE, S_GAME_OVER
  } state_t;

  // Encoding 11 is folded into STANDBY, so only LIGHT/HEAVY count as attacks.
  function automatic logic is_attack(input logic [1:0] t);
    return (t == ATK_LIGHT) || (t == ATK_HEAVY);
  endfunction
endpackage

// File: rtl/damage_calc.sv
// Combinational damage lookup: attack type and hit result to 3-bit damage.
module damage_calc
  import battle_pkg::*;
(
  input  logic [1:0] i_type,
  input  logic [1:0] i_hit,
  output logic [2:0] o_dmg
);
  always_comb begin
    o_dmg = 3'd0;
    case (i_type)
      ATK_LIGHT: begin
        if (i_hit == HIT_NORMAL)    o_dmg = 3'd1;
        else if (i_hit == HIT_CRIT) o_dmg = 3'd2;
      end
      ATK_HEAVY: begin
        if (i_hit == HIT_NORMAL)    o_dmg = 3'd2;
        else if (i_hit == HIT_CRIT) o_dmg = 3'd4;
      end
      default: o_dmg = 3'd0;
    endcase
  end
endmodule

// File: rtl/battle_turn_ctrl.sv
// Player-vs-CPU turn sequencer: hands attacks to the resolver and applies saturating damage.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
  parameter int HEALTH_W     = 8,
  parameter int TURN_TIMEOUT = 1000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_p1_valid,
  input  logic [1:0]          i_p1_type,
  output logic                o_p1_ready,
  input  logic [1:0]          i_cpu_type,
  output logic                o_res_req,
  output logic                o_res_player,
  output logic [1:0]          o_res_type,
  input  logic                i_res_valid,
  input  logic [1:0]          i_res_state,
  output logic [HEALTH_W-1:0] o_p1_health,
  output logic [HEALTH_W-1:0] o_cpu_health,
  output logic                o_cpu_attacking,
  output logic                o_turn_p1,
  output logic                o_game_over,
  output logic                o_winner,
  output logic [7:0]          o_round
);
  localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0]       TO_LAST = CW'(TURN_TIMEOUT - 1);
  localparam logic [HEALTH_W-1:0] HMAX    = HEALTH_W'(MAX_HEALTH);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          type_q;
  logic [HEALTH_W-1:0] p1_hp_q, cpu_hp_q, p1_hp_new, cpu_hp_new, dmg_w;
  logic [7:0]          round_q;
  logic                winner_q, cpu_atk_q;
  logic [2:0]          dmg;

  // One lookup serves both turns; the state picks which health it lands on.
  damage_calc u_dmg (.i_type(type_q), .i_hit(i_res_state), .o_dmg(dmg));

  assign dmg_w      = HEALTH_W'(dmg);
  assign p1_hp_new  = (p1_hp_q  > dmg_w) ? p1_hp_q  - dmg_w : '0;
  assign cpu_hp_new = (cpu_hp_q > dmg_w) ? cpu_hp_q - dmg_w : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: if (i_start) state_d = S_P1_TURN;
      S_P1_TURN: begin
        if (i_p1_valid)            state_d = is_attack(i_p1_type) ? S_P1_RESOLVE : S_CPU_TURN;
        else if (cnt_q == TO_LAST) state_d = S_CPU_TURN;
      end
      S_P1_RESOLVE:  if (i_res_valid) state_d = (cpu_hp_new == '0) ? S_GAME_OVER : S_CPU_TURN;
      S_CPU_TURN:    state_d = is_attack(i_cpu_type) ? S_CPU_RESOLVE : S_P1_TURN;
      S_CPU_RESOLVE: if (i_res_valid) state_d = (p1_hp_new == '0) ? S_GAME_OVER : S_P1_TURN;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_p1_ready   = (state_q == S_P1_TURN);
    o_turn_p1    = (state_q == S_P1_TURN);
    o_res_req    = (state_q == S_P1_RESOLVE) || (state_q == S_CPU_RESOLVE);
    o_res_player = (state_q == S_P1_RESOLVE);
    o_res_type   = o_res_req ? type_q : ATK_STANDBY;
    o_game_over  = (state_q == S_GAME_OVER);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      type_q    <= ATK_STANDBY;
      p1_hp_q   <= HMAX;
      cpu_hp_q  <= HMAX;
      round_q   <= 8'd0;
      winner_q  <= 1'b0;
      cpu_atk_q <= 1'b0;
    end else begin
      cpu_atk_q <= 1'b0;
      cnt_q     <= (state_q == S_P1_TURN) ? cnt_q + CW'(1) : '0;
      case (state_q)
        S_IDLE, S_GAME_OVER: if (i_start) begin
          p1_hp_q  <= HMAX;
          cpu_hp_q <= HMAX;
          round_q  <= 8'd1;
          winner_q <= 1'b0;
        end
        S_P1_TURN: if (i_p1_valid) type_q <= i_p1_type;
        S_P1_RESOLVE: if (i_res_valid) begin
          cpu_hp_q <= cpu_hp_new;
          if (cpu_hp_new == '0) winner_q <= 1'b1;
        end
        S_CPU_TURN: begin
          type_q <= i_cpu_type;
          if (!is_attack(i_cpu_type) && round_q != 8'hFF) round_q <= round_q + 8'd1;
        end
        S_CPU_RESOLVE: if (i_res_valid) begin
          p1_hp_q   <= p1_hp_new;
          cpu_atk_q <= (i_res_state == HIT_CRIT) || (i_res_state == HIT_NORMAL);
          if (p1_hp_new == '0)        winner_q <= 1'b0;
          else if (round_q != 8'hFF)  round_q  <= round_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_p1_health     = p1_hp_q;
  assign o_cpu_health    = cpu_hp_q;
  assign o_round         = round_q;
  assign o_winner        = winner_q;
  assign o_cpu_attacking = cpu_atk_q;
endmodule
